// File: rtl/trigger_capture_pkg.sv
// Shared types and size helpers for the trigger capture buffer.
// Sizes depend on the instance parameters, so they are provided as functions.
package trigger_capture_pkg;

  localparam int unsigned DataBitsDef   = 12;
  localparam int unsigned AddrBitsDef   = 10;
  localparam int unsigned PreTriggerDef = 256;

  typedef enum logic [2:0] {
    StIdle,
    StPretrig,
    StArmed,
    StPost,
    StDone
  } state_e;

  typedef struct packed {
    logic trigger_disable;
    logic busy;
    logic capture_done;
  } status_t;

  function automatic int unsigned depth_of(int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  function automatic int unsigned post_count_of(int unsigned addr_bits, int unsigned pre);
    return depth_of(addr_bits) - pre;
  endfunction

  function automatic status_t status_of(state_e s);
    status_t st;
    st.trigger_disable = (s != StArmed);
    st.busy            = (s == StPretrig) || (s == StArmed) || (s == StPost);
    st.capture_done    = (s == StDone);
    return st;
  endfunction

endpackage

// File: rtl/trigger_capture_buffer_if.sv
// Trigger/sample stream, control, status and readback signals of the capture buffer.
// master drives samples and requests; slave is the capture buffer.
interface trigger_capture_buffer_if #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned ADDR_BITS = 10
);
  logic                 dataReady;
  logic [DATA_BITS-1:0] dataIn;
  logic                 isTriggered;
  logic                 forceTrigger;
  logic                 arm;
  logic                 triggerDisable;
  logic                 busy;
  logic                 captureDone;
  logic [ADDR_BITS-1:0] triggerAddr;
  logic                 readEn;
  logic [ADDR_BITS-1:0] readAddr;
  logic [DATA_BITS-1:0] readData;
  logic                 readValid;

  modport master (
    output dataReady, dataIn, isTriggered, forceTrigger, arm, readEn, readAddr,
    input  triggerDisable, busy, captureDone, triggerAddr, readData, readValid
  );

  modport slave (
    input  dataReady, dataIn, isTriggered, forceTrigger, arm, readEn, readAddr,
    output triggerDisable, busy, captureDone, triggerAddr, readData, readValid
  );
endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (latency 1).
// The read register only loads on re, so rdata holds between honoured reads.
module capture_ram
  import trigger_capture_pkg::*;
#(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);
  localparam int unsigned Depth = depth_of(ADDR_BITS);

  logic [DATA_BITS-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Capture FSM: records samples circularly around an accepted trigger, then freezes
// the record for readback. Status outputs are registered decodes of the next state.
module trigger_capture_buffer
  import trigger_capture_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DataBitsDef,
  parameter int unsigned ADDR_BITS   = AddrBitsDef,
  parameter int unsigned PRE_TRIGGER = PreTriggerDef
) (
  input logic                    clock,
  input logic                    reset_n,
  trigger_capture_buffer_if.slave bus
);
  localparam int unsigned          CntBits   = ADDR_BITS + 1;
  localparam logic [CntBits-1:0]   PreCnt    = CntBits'(PRE_TRIGGER);
  localparam logic [CntBits-1:0]   PostCnt   = CntBits'(post_count_of(ADDR_BITS, PRE_TRIGGER));
  localparam logic [ADDR_BITS-1:0] PreOffset = ADDR_BITS'(PRE_TRIGGER);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] write_ptr_q;
  logic [ADDR_BITS-1:0] trig_addr_q, trig_addr_d;
  logic [CntBits-1:0]   count_q, count_d;
  logic [ADDR_BITS-1:0] read_addr;
  logic                 wr_en, rd_en, trig_hit;
  logic                 read_valid_q;
  status_t              status_q;

  assign trig_hit  = (bus.dataReady && bus.isTriggered) || bus.forceTrigger;
  assign rd_en     = bus.readEn && (state_q == StDone);
  assign read_addr = trig_addr_q - PreOffset + bus.readAddr;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    trig_addr_d = trig_addr_q;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.arm) begin
          count_d = '0;
          state_d = (PRE_TRIGGER == 0) ? StArmed : StPretrig;
        end
      end
      StPretrig: begin
        if (bus.dataReady) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_d == PreCnt) state_d = StArmed;
        end
      end
      StArmed: begin
        wr_en = bus.dataReady;
        if (trig_hit) begin
          // A sample arriving with the trigger is the first post-trigger sample.
          trig_addr_d = write_ptr_q;
          count_d     = CntBits'(bus.dataReady);
          state_d     = (count_d == PostCnt) ? StDone : StPost;
        end
      end
      StPost: begin
        if (bus.dataReady) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_d == PostCnt) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      write_ptr_q  <= '0;
      count_q      <= '0;
      trig_addr_q  <= '0;
      read_valid_q <= 1'b0;
      status_q     <= status_of(StIdle);
    end else begin
      state_q      <= state_d;
      write_ptr_q  <= write_ptr_q + ADDR_BITS'(wr_en);
      count_q      <= count_d;
      trig_addr_q  <= trig_addr_d;
      read_valid_q <= rd_en;
      status_q     <= status_of(state_d);
    end
  end

  assign bus.triggerDisable = status_q.trigger_disable;
  assign bus.busy           = status_q.busy;
  assign bus.captureDone    = status_q.capture_done;
  assign bus.triggerAddr    = trig_addr_q;
  assign bus.readValid      = read_valid_q;

  capture_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wr_en),
    .waddr   (write_ptr_q),
    .wdata   (bus.dataIn),
    .re      (rd_en),
    .raddr   (read_addr),
    .rdata   (bus.readData)
  );

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Directed bench for trigger_capture_buffer with a 16-entry record and 4 pre-trigger samples.
module tb_trigger_capture_buffer;
  localparam int unsigned DW  = 12;
  localparam int unsigned AW  = 4;
  localparam int unsigned PRE = 4;

  logic clock = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  trigger_capture_buffer_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  trigger_capture_buffer #(
    .DATA_BITS   (DW),
    .ADDR_BITS   (AW),
    .PRE_TRIGGER (PRE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input int unsigned td, input int unsigned bz,
                              input int unsigned dn);
    check({tag, ".triggerDisable"}, int'(bus.triggerDisable), td);
    check({tag, ".busy"}, int'(bus.busy), bz);
    check({tag, ".captureDone"}, int'(bus.captureDone), dn);
  endtask

  // One sample: strobe for a cycle, then an idle cycle.
  task automatic sample(input int unsigned value, input logic trig);
    bus.dataReady   = 1'b1;
    bus.dataIn      = DW'(value);
    bus.isTriggered = trig;
    tick();
    bus.dataReady   = 1'b0;
    bus.isTriggered = 1'b0;
    tick();
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic read_check(input string tag, input int unsigned addr, input int unsigned exp);
    bus.readEn   = 1'b1;
    bus.readAddr = AW'(addr);
    tick();
    bus.readEn = 1'b0;
    check({tag, ".readValid"}, int'(bus.readValid), 1);
    check({tag, ".readData"}, int'(bus.readData), exp);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.dataReady    = 1'b0;
    bus.dataIn       = '0;
    bus.isTriggered  = 1'b0;
    bus.forceTrigger = 1'b0;
    bus.arm          = 1'b0;
    bus.readEn       = 1'b0;
    bus.readAddr     = '0;
    tick();
    tick();
    check_status("reset", 1, 0, 0);
    check("reset.triggerAddr", int'(bus.triggerAddr), 0);
    check("reset.readValid", int'(bus.readValid), 0);
    check("reset.readData", int'(bus.readData), 0);
    reset_n = 1'b1;

    // 1: no arm, samples must not start an acquisition
    for (int k = 0; k < 50; k++) sample(k, (k % 7) == 3);
    check_status("t1.idle", 1, 0, 0);

    // 2: trigger on sample 10 with writePtr starting at 0
    do_arm();
    check_status("t2.arm", 1, 1, 0);
    for (int k = 0; k < 10; k++) sample(k, 1'b0);
    check_status("t2.armed", 0, 1, 0);
    for (int k = 10; k < 21; k++) sample(k, k == 10);
    check_status("t2.post", 1, 1, 0);
    sample(21, 1'b0);
    check_status("t2.done", 1, 0, 1);
    check("t2.triggerAddr", int'(bus.triggerAddr), 10);
    for (int i = 0; i < 16; i++) read_check($sformatf("t2.rd%0d", i), i, 6 + i);

    // 3: trigger inside PRETRIG ignored; real trigger on sample 12 from writePtr=6
    do_arm();
    sample(0, 1'b0);
    sample(1, 1'b0);
    sample(2, 1'b1);
    check_status("t3.pretrig", 1, 1, 0);
    sample(3, 1'b0);
    check_status("t3.armed", 0, 1, 0);
    for (int k = 4; k < 24; k++) sample(k, k == 12);
    check_status("t3.done", 1, 0, 1);
    check("t3.triggerAddr", int'(bus.triggerAddr), 2);
    read_check("t3.rd0", 0, 8);
    read_check("t3.rd4", 4, 12);
    read_check("t3.rd15", 15, 23);

    // 4: writePtr=14, trigger on sample 5 -> record wraps
    do_arm();
    for (int k = 0; k < 17; k++) sample(k, k == 5);
    check_status("t4.done", 1, 0, 1);
    check("t4.triggerAddr", int'(bus.triggerAddr), 3);
    read_check("t4.rd4", 4, 5);
    read_check("t4.rd0", 0, 1);
    read_check("t4.rd15", 15, 16);

    // 5: arm during POST ignored; arm + readEn together in DONE
    do_arm();
    for (int k = 0; k < 8; k++) sample(k, k == 4);
    do_arm();
    check_status("t5.post_arm", 1, 1, 0);
    for (int k = 8; k < 15; k++) sample(k, 1'b0);
    check_status("t5.post", 1, 1, 0);
    sample(15, 1'b0);
    check_status("t5.done", 1, 0, 1);
    bus.arm      = 1'b1;
    bus.readEn   = 1'b1;
    bus.readAddr = AW'(5);
    tick();
    bus.arm    = 1'b0;
    bus.readEn = 1'b0;
    check("t5.armrd.readValid", int'(bus.readValid), 1);
    check("t5.armrd.readData", int'(bus.readData), 5);
    check_status("t5.armrd", 1, 1, 0);
    bus.readEn   = 1'b1;
    bus.readAddr = '0;
    tick();
    bus.readEn = 1'b0;
    check("t5.rdbusy.readValid", int'(bus.readValid), 0);
    check("t5.rdbusy.readData", int'(bus.readData), 5);

    // 6: reset in POST abandons the record
    for (int k = 0; k < 7; k++) sample(k, k == 4);
    check_status("t6.post", 1, 1, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_status("t6.reset", 1, 0, 0);
    check("t6.reset.triggerAddr", int'(bus.triggerAddr), 0);
    for (int k = 0; k < 12; k++) sample(100 + k, 1'b0);
    check_status("t6.idle", 1, 0, 0);

    // 6b: forceTrigger without a sample; writePtr restarted at 0 after reset
    do_arm();
    for (int k = 0; k < 6; k++) sample(k, 1'b0);
    check_status("t6.armed", 0, 1, 0);
    bus.forceTrigger = 1'b1;
    tick();
    bus.forceTrigger = 1'b0;
    check_status("t6.force", 1, 1, 0);
    check("t6.force.triggerAddr", int'(bus.triggerAddr), 6);
    for (int k = 6; k < 17; k++) sample(k, 1'b0);
    check_status("t6.post11", 1, 1, 0);
    sample(17, 1'b0);
    check_status("t6.done", 1, 0, 1);
    read_check("t6.rd4", 4, 6);
    read_check("t6.rd0", 0, 2);
    read_check("t6.rd15", 15, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
